// File: rtl/ram_fifo_level_if_if.sv
// Handshake and RAM strobe bundle for the RAM-backed FIFO controller.
// master = producer/consumer side, slave = FIFO controller side.
interface ram_fifo_level_if_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              in_clke_o;
    logic [ADDR_W-1:0] in_addr_o;
    logic              out_clke_o;
    logic [ADDR_W-1:0] out_addr_o;

    modport master (
        output in_valid_i, out_ready_i,
        input  in_ready_o, out_valid_o,
        input  in_clke_o, in_addr_o, out_clke_o, out_addr_o
    );

    modport slave (
        input  in_valid_i, out_ready_i,
        output in_ready_o, out_valid_o,
        output in_clke_o, in_addr_o, out_clke_o, out_addr_o
    );
endinterface

// File: rtl/ram_fifo_level_if.sv
// RAM-backed FIFO controller: address/strobe generation, output stage, level flags.
// Optional sticky overflow flag enabled by defining RAM_FIFO_OVERFLOW_EN.
module ram_fifo_level_if #(
    parameter int RAM_SIZE     = 1024,
    parameter int AFULL_LEVEL  = RAM_SIZE - 4,
    parameter int AEMPTY_LEVEL = 4,
    localparam int ADDR_W      = $clog2(RAM_SIZE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                flush_i,
    ram_fifo_level_if_if.slave  bus,
    output logic                empty_o,
    output logic                full_o,
    output logic [ADDR_W+1:0]   level_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    input  logic                clear_err_i,
    output logic                overflow_o
);
    localparam logic [ADDR_W+1:0] AF = (ADDR_W+2)'(AFULL_LEVEL);
    localparam logic [ADDR_W+1:0] AE = (ADDR_W+2)'(AEMPTY_LEVEL);

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_out_valid;

    logic            w_clear;
    logic            w_ram_empty;
    logic            w_full;
    logic            w_wr;
    logic            w_rd_en;
    logic            w_ov_nxt;
    logic [ADDR_W:0] w_diff;

    assign w_clear     = ~en_i | flush_i;
    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &
                         (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    assign bus.in_ready_o = en_i & ~flush_i & ~rst_i & ~w_full;
    assign w_wr           = bus.in_valid_i & bus.in_ready_o;
    assign bus.in_clke_o  = w_wr;
    assign bus.in_addr_o  = r_wr_ptr[ADDR_W-1:0];

    always_comb begin
        w_rd_en  = 1'b0;
        w_ov_nxt = r_out_valid;
        unique case (1'b1)
            (~r_out_valid & ~w_ram_empty): begin
                w_rd_en  = 1'b1;
                w_ov_nxt = 1'b1;
            end
            (r_out_valid & bus.out_ready_i & ~w_ram_empty): begin
                w_rd_en = 1'b1;
            end
            (r_out_valid & bus.out_ready_i & w_ram_empty): begin
                w_ov_nxt = 1'b0;
            end
            default: ;
        endcase
        // No RAM access while the FIFO is being cleared
        if (rst_i | w_clear) w_rd_en = 1'b0;
    end

    assign bus.out_clke_o  = w_rd_en;
    assign bus.out_addr_o  = r_rd_ptr[ADDR_W-1:0];
    assign bus.out_valid_o = r_out_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i | w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr)    r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_out_valid <= w_ov_nxt;
        end
    end

    assign w_diff  = r_wr_ptr - r_rd_ptr;
    assign level_o = {1'b0, w_diff} + {{(ADDR_W+1){1'b0}}, r_out_valid};

    assign empty_o        = w_ram_empty & ~r_out_valid;
    assign full_o         = w_full;
    assign almost_full_o  = (level_o >= AF);
    assign almost_empty_o = (level_o <= AE);

`ifdef RAM_FIFO_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_overflow <= 1'b0;
        else if (en_i & ~flush_i & bus.in_valid_i & w_full)
            r_overflow <= 1'b1;
        else if (clear_err_i | w_clear)
            r_overflow <= 1'b0;
    end

    assign overflow_o = r_overflow;
`else
    logic w_unused_clear_err;

    assign w_unused_clear_err = clear_err_i;
    assign overflow_o         = 1'b0;
`endif
endmodule

// File: tb/tb_ram_fifo_level_if.sv
// Bench for ram_fifo_level_if: RAM_SIZE=8 with a count/queue reference model,
// directed scenarios and randomized traffic.
module tb_ram_fifo_level_if;
    localparam int RS = 8;
    localparam int AW = 3;
    localparam int AFL = 6;
    localparam int AEL = 2;

    logic          clk = 1'b0;
    logic          rst, en, flush, clear_err;
    logic          empty, full, afull, aempty, ovf;
    logic [AW+1:0] level;
    logic [7:0]    wdata, rdata;
    logic [7:0]    mem [RS];

    int n_chk = 0;
    int n_fail = 0;

    ram_fifo_level_if_if #(.ADDR_W(AW)) bus ();

    ram_fifo_level_if #(
        .RAM_SIZE(RS), .AFULL_LEVEL(AFL), .AEMPTY_LEVEL(AEL)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
        .bus(bus.slave),
        .empty_o(empty), .full_o(full), .level_o(level),
        .almost_full_o(afull), .almost_empty_o(aempty),
        .clear_err_i(clear_err), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.in_clke_o) mem[bus.in_addr_o] <= wdata;
        if (bus.out_clke_o) rdata <= mem[bus.out_addr_o];
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stored-word count, output stage flag, absolute counts
    int        m_cnt = 0;
    bit        m_ov = 0;
    int        m_wcnt = 0;
    int        m_rcnt = 0;
    bit        m_ovf = 0;
    logic [7:0] q[$];

    always @(negedge clk) begin
        bit clr, e_rdy, e_wr, e_rd;
        int e_lvl;
        clr   = !en || flush;
        e_rdy = !rst && !clr && (m_cnt != RS);
        e_wr  = bus.in_valid_i && e_rdy;
        e_rd  = !rst && !clr && (m_cnt != 0) && (!m_ov || bus.out_ready_i);
        e_lvl = m_cnt + int'(m_ov);
        chk("in_ready", 32'(bus.in_ready_o), 32'(e_rdy));
        chk("in_clke", 32'(bus.in_clke_o), 32'(e_wr));
        if (e_wr) chk("in_addr", 32'(bus.in_addr_o), 32'(m_wcnt % RS));
        chk("out_clke", 32'(bus.out_clke_o), 32'(e_rd));
        if (e_rd) chk("out_addr", 32'(bus.out_addr_o), 32'(m_rcnt % RS));
        chk("out_valid", 32'(bus.out_valid_o), 32'(m_ov));
        chk("empty", 32'(empty), 32'(e_lvl == 0));
        chk("full", 32'(full), 32'(m_cnt == RS));
        chk("level", 32'(level), 32'(e_lvl));
        chk("afull", 32'(afull), 32'(e_lvl >= AFL));
        chk("aempty", 32'(aempty), 32'(e_lvl <= AEL));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        if (!rst && !clr && m_ov && bus.out_ready_i) begin
            if (q.size() == 0) begin
                chk("data_avail", 32'(0), 32'(1));
            end else begin
                chk("data", 32'(rdata), 32'(q[0]));
                void'(q.pop_front());
            end
        end
`ifdef RAM_FIFO_OVERFLOW_EN
        if (rst) m_ovf = 0;
        else if (en && !flush && bus.in_valid_i && m_cnt == RS) m_ovf = 1;
        else if (clear_err || clr) m_ovf = 0;
`endif
        if (rst || clr) begin
            m_cnt = 0; m_ov = 0; m_wcnt = 0; m_rcnt = 0;
            q.delete();
        end else begin
            if (e_wr) begin
                q.push_back(wdata);
                m_cnt++;
                m_wcnt++;
            end
            if (e_rd) begin
                m_cnt--;
                m_rcnt++;
                m_ov = 1;
            end else if (m_ov && bus.out_ready_i) begin
                m_ov = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_ovf;
        bit   done;
        rst = 1; en = 1; flush = 0; clear_err = 0;
        bus.in_valid_i = 0; bus.out_ready_i = 0; wdata = 8'h00;
        cyc(); cyc();
        rst = 0;
        @(negedge clk);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_ready", 32'(bus.in_ready_o), 1);
        chk("rst_ovf", 32'(ovf), 0);

        // Latency: write at N, read strobe at N+1, valid at N+2
        cyc();
        bus.in_valid_i = 1; wdata = 8'hA5;
        @(negedge clk);
        chk("lat_in_clke", 32'(bus.in_clke_o), 1);
        cyc();
        bus.in_valid_i = 0;
        @(negedge clk);
        chk("lat_out_clke", 32'(bus.out_clke_o), 1);
        chk("lat_valid_n1", 32'(bus.out_valid_o), 0);
        cyc();
        @(negedge clk);
        chk("lat_valid_n2", 32'(bus.out_valid_o), 1);
        chk("lat_rdata", 32'(rdata), 32'hA5);
        cyc();
        bus.out_ready_i = 1;
        cyc();
        bus.out_ready_i = 0;
        @(negedge clk);
        chk("lat_drained", 32'(level), 0);

        // Fill to RAM_SIZE+1 with consumer stalled, then hold in_valid while full
        cyc();
        for (int i = 0; i < 9; i++) begin
            bus.in_valid_i = 1; wdata = 8'($urandom);
            cyc();
        end
        @(negedge clk);
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(level), 9);
        chk("fill_ready", 32'(bus.in_ready_o), 0);
        chk("fill_afull", 32'(afull), 1);
        cyc();
        bus.in_valid_i = 0;
`ifdef RAM_FIFO_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        @(negedge clk);
        chk("ovf_set", 32'(ovf), 32'(exp_ovf));
        cyc();
        @(negedge clk);
        chk("ovf_sticky", 32'(ovf), 32'(exp_ovf));
        cyc();
        clear_err = 1;
        cyc();
        clear_err = 0;
        @(negedge clk);
        chk("ovf_cleared", 32'(ovf), 0);

        // Drain with a bounded wait
        cyc();
        bus.out_ready_i = 1;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (empty) done = 1;
            else cyc();
        end
        chk("drain_done", 32'(done), 1);
        cyc();
        bus.out_ready_i = 0;

        // Clear mid-stream via flush_i, then via en_i low
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                bus.in_valid_i = 1; wdata = 8'($urandom);
                cyc();
            end
            @(negedge clk);
            chk("clr_level5", 32'(level), 5);
            cyc();
            if (k == 0) flush = 1;
            else en = 0;
            @(negedge clk);
            chk("clr_in_clke", 32'(bus.in_clke_o), 0);
            chk("clr_out_clke", 32'(bus.out_clke_o), 0);
            cyc();
            flush = 0; en = 1; bus.in_valid_i = 0;
            @(negedge clk);
            chk("clr_level0", 32'(level), 0);
            chk("clr_valid", 32'(bus.out_valid_o), 0);
            chk("clr_wptr", 32'(bus.in_addr_o), 0);
            chk("clr_rptr", 32'(bus.out_addr_o), 0);
            cyc();
        end

        // Streaming: one word per clock, addresses wrap
        for (int i = 0; i < 45; i++) begin
            bus.in_valid_i = 1; bus.out_ready_i = 1; wdata = 8'($urandom);
            cyc();
        end

        // Randomized traffic with occasional flush, disable, reset, clear_err
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph = (i / 500) % 3;
            bus.in_valid_i  = ($urandom_range(0, 9) < (ph == 0 ? 8 : 4));
            bus.out_ready_i = ($urandom_range(0, 9) < (ph == 1 ? 8 : 3));
            wdata     = 8'($urandom);
            flush     = ($urandom_range(0, 79) == 0);
            en        = ($urandom_range(0, 79) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            clear_err = ($urandom_range(0, 19) == 0);
            cyc();
        end
        rst = 0; en = 1; flush = 0; clear_err = 0;
        bus.in_valid_i = 0; bus.out_ready_i = 1;
        for (int i = 0; i < 20; i++) cyc();
        @(negedge clk);
        chk("final_empty", 32'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_fifo_level_if.md
Name: ram_fifo_level_if

Overview:
Parametrised controller for a RAM-backed FIFO with single-cycle-latency synchronous RAM.
- Generates write and read address/clock-enable strobes.
- Keeps a registered output-valid stage and reports fill level with programmable almost-full/almost-empty flags.
- Supports synchronous flush.
- Sits between USB/application producers and a block RAM, replacing fixed-behaviour FIFO address generators.

Parameters:
RAM_SIZE, 1024, RAM depth in words; power of two, >= 2; ADDR_W = ceil_log2(RAM_SIZE)
AFULL_LEVEL, RAM_SIZE-4, almost_full_o threshold (level_o >= AFULL_LEVEL)
AEMPTY_LEVEL, 4, almost_empty_o threshold (level_o <= AEMPTY_LEVEL)

Ports:
clk_i  in  1  single clock; all logic on rising edge
rst_i  in  1  reset; synchronous, active-high
en_i  in  1  low: FIFO held cleared, same as flush
flush_i  in  1  one-cycle synchronous clear pulse
in_valid_i  in  1  producer has word on RAM write data
in_ready_o  out  1  FIFO can accept a word
out_valid_o  out  1  RAM read data valid to consumer
out_ready_i  in  1  consumer takes word
in_clke_o  out  1  RAM write enable
in_addr_o  out  ADDR_W  RAM write address
out_clke_o  out  1  RAM read clock enable
out_addr_o  out  ADDR_W  RAM read address
empty_o  out  1  no stored words and no valid output
full_o  out  1  RAM holds RAM_SIZE unread words
level_o  out  ADDR_W+2  words held (RAM + output stage), max RAM_SIZE+1
almost_full_o  out  1  level_o >= AFULL_LEVEL
almost_empty_o  out  1  level_o <= AEMPTY_LEVEL
clear_err_i  in  1  clears overflow_o (optional feature)
overflow_o  out  1  sticky overflow flag (optional feature)

Behaviour:
State:
- wr_ptr, rd_ptr: ADDR_W+1 bits, wrap modulo 2*RAM_SIZE; out_valid_q: 1 bit.
- ram_empty = (wr_ptr == rd_ptr).
- full = low ADDR_W bits equal, MSB differ.
- level_o = (wr_ptr - rd_ptr) + out_valid_q, computed at ADDR_W+2 bits.

Reset (rst_i high at clock edge):
- wr_ptr = rd_ptr = 0; out_valid_o = 0; overflow_o = 0.
- Resulting outputs: empty_o = 1, full_o = 0, level_o = 0, almost_empty_o = 1, almost_full_o = 0.
- in_ready_o is combinationally 0 while rst_i = 1.
- Reset mid-transfer discards all contents.

Clear (~en_i or flush_i), priority below reset, above everything else:
- Next state equals reset state; overflow_o is also cleared.
- in_ready_o = 0, in_clke_o = 0, out_clke_o = 0 in that cycle.

Write path:
- in_ready_o = en_i & ~flush_i & ~rst_i & ~full.
- On in_valid_i & in_ready_o: in_clke_o = 1, in_addr_o = wr_ptr[ADDR_W-1:0], wr_ptr++.
- in_clke_o and out_clke_o are combinational same-cycle strobes.

Read path (priority order):
- ~out_valid_q & ~ram_empty: prefetch. out_clke_o = 1, out_addr_o = rd_ptr low bits, rd_ptr++, out_valid_q <= 1. Data appears at RAM output together with out_valid_o next cycle.
- out_valid_q & out_ready_i & ~ram_empty: out_clke_o = 1, rd_ptr++, out_valid_q stays 1 (back-to-back, one word per clock).
- out_valid_q & out_ready_i & ram_empty: out_valid_q <= 0.
- out_valid_q & ~out_ready_i: hold; out_clke_o = 0 so RAM output stays stable.

Flags and latency:
- empty_o = ram_empty & ~out_valid_q. Write into empty FIFO at cycle N -> out_clke_o at N+1 -> out_valid_o at N+2.
- Simultaneous write and read: both pointers advance; a word written in cycle N is never read before N+1.
- When full, in_ready_o = 0 even if a read occurs the same cycle (no write-through). Ready reasserts the cycle after the read.
- Flags are combinational from registered state; no extra latency.

Optional Feature:
RAM_FIFO_OVERFLOW_EN
- Defined: overflow_o sets (sticky) on any cycle with en_i & ~flush_i & in_valid_i & full. It clears on clear_err_i, flush_i, ~en_i, or rst_i; set has priority over clear_err_i in the same cycle.
- Not defined: overflow_o is tied to 0 and clear_err_i is ignored.
- Ports are present in both builds.

Test Plan:
- Reset, then idle -> empty_o=1, level_o=0, almost_empty_o=1, in_ready_o=1; after one write, out_valid_o rises exactly 2 cycles later.
- RAM_SIZE=8: 8 writes with out_ready_i=0 -> level_o=8 after the prefetch (out_valid_o=1, RAM holds 7), then a 9th write accepted, full_o=1, level_o=9, in_ready_o=0.
- Continuous in_valid_i=out_ready_i=1 for 40 words at RAM_SIZE=8 -> one word per cycle after warm-up, addresses wrap 7->0, data in order, no loss.
- AFULL_LEVEL=6, AEMPTY_LEVEL=2, RAM_SIZE=8: fill 0->9 and drain -> almost_full_o exactly when level_o>=6, almost_empty_o exactly when level_o<=2.
- flush_i mid-stream with level_o=5 and in_valid_i=1 -> no in_clke_o that cycle, next cycle level_o=0, out_valid_o=0, pointers 0. Repeat with en_i low: same result.
- With RAM_FIFO_OVERFLOW_EN: in_valid_i held while full -> overflow_o=1 next cycle, stays 1 until clear_err_i pulse. Without the macro -> overflow_o=0 throughout.
